serial_byte_tx: RTL

SERIAL_BYTE_TX -- requirements
Module: serial_byte_tx

---
 rtl/serial_byte_tx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/serial_byte_tx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_byte_tx
//  Purpose  : Byte-to-serial transmitter. Sends a frame of start bit (0),
//             8 data bits (LSB- or MSB-first), optional even parity bit and
//             stop bit (1). Each bit lasts CLKS_PER_BIT clocks. A one-cycle
//             shift_mode strobe on the last cycle of every data bit lets a
//             downstream modal shift register rebuild the byte from Ser.
//  Ports    : Clk        - clock, all logic on rising edge
//             Rst        - synchronous active-high reset
//             D          - byte to send, captured on accept
//             valid      - D/msb_first present, held until accepted
//             msb_first  - 0 = LSB first, 1 = MSB first
//             ready      - block can accept a byte this cycle (IDLE)
//             Ser        - registered serial line, idles high
//             shift_mode - 001 shift right (Ser->bit7), 010 shift left
//                          (Ser->bit0), 000 hold
//             busy       - frame in progress
//             done       - one-cycle pulse in the first IDLE cycle after STOP
//  Revision : 1.0 - initial release
// ============================================================================
module serial_byte_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] D,
    input  logic       valid,
    input  logic       msb_first,
    output logic       ready,
    output logic       Ser,
    output logic [2:0] shift_mode,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Bit-period counter counts down from this value to 0.
    localparam logic [7:0] C_RELOAD = 8'(CLKS_PER_BIT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic       msbf_q, msbf_d;
    logic       par_q, par_d;
    logic       ser_q, ser_d;
    logic [2:0] mode_q, mode_d;
    logic       done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        msbf_d  = msbf_q;
        par_d   = par_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // ready is high in IDLE, so valid alone means accept.
                if (valid) begin
                    data_d  = D;
                    msbf_d  = msb_first;
                    par_d   = ^D;
                    state_d = S_START;
                    cnt_d   = C_RELOAD;
                    idx_d   = 3'd0;
                end
            end
            S_START: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_DATA;
                    cnt_d   = C_RELOAD;
                    idx_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == 8'd0) begin
                    cnt_d = C_RELOAD;
                    if (idx_q == 3'd7) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_PARITY: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_STOP;
                    cnt_d   = C_RELOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are computed from next-state values so the registered
        // Ser/shift_mode line up with the state they describe.
        case (state_d)
            S_START:  ser_d = 1'b0;
            S_DATA:   ser_d = msbf_d ? data_d[3'd7 - idx_d] : data_d[idx_d];
            S_PARITY: ser_d = par_d;
            default:  ser_d = 1'b1;
        endcase

        // Strobe on the final cycle of each data bit period.
        if ((state_d == S_DATA) && (cnt_d == 8'd0)) begin
            mode_d = msbf_d ? 3'b010 : 3'b001;
        end else begin
            mode_d = 3'b000;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            data_q  <= 8'd0;
            msbf_q  <= 1'b0;
            par_q   <= 1'b0;
            ser_q   <= 1'b1;
            mode_q  <= 3'b000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            msbf_q  <= msbf_d;
            par_q   <= par_d;
            ser_q   <= ser_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign ready      = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign Ser        = ser_q;
    assign shift_mode = mode_q;
    assign done       = done_q;

endmodule
`default_nettype wire
